// File: rtl/ring_osc_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ring_osc_timer_ctrl
// Brief    : Sequences the ring-oscillator timer and accumulates 2^ACCUM_LOG2
//            synchronised count readings into one handshaked result.
// Revision : 1.0  initial release
// ============================================================================
module ring_osc_timer_ctrl #(
    parameter int WINDOW_W      = 16,
    parameter int ARM_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACCUM_LOG2    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WINDOW_W-1:0]   window,
    input  logic [7:0]            timer_out,
    output logic                  timer_slow_clk,
    output logic                  timer_enable,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [6+ACCUM_LOG2-1:0] result_count,
    output logic                  result_signal,
    output logic                  result_overflow
);

    localparam int ACC_W = 6 + ACCUM_LOG2;
    localparam int IDX_W = (ACCUM_LOG2 > 0) ? ACCUM_LOG2 : 1;
    localparam int ARM_W = $clog2(ARM_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = (WINDOW_W > ARM_W)
                         ? ((WINDOW_W > SET_W) ? WINDOW_W : SET_W)
                         : ((ARM_W > SET_W) ? ARM_W : SET_W);

    localparam logic [CNT_W-1:0] C_ARM_LOAD    = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_IDX_LAST    = IDX_W'((1 << ACCUM_LOG2) - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE     = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_MEASURE = 3'd2,
        S_SETTLE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_sync_meta;
    logic [7:0]         r_sync;
    logic [CNT_W-1:0]   r_cnt;
    logic [WINDOW_W-1:0] r_window;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_idx;

    logic               w_cnt_done;
    logic               w_last;
    logic               w_capture;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_slow_clk_nxt;
    logic               w_enable_nxt;
    logic               w_busy_nxt;
    logic               w_valid_nxt;

    // Raw timer status is asynchronous; only r_sync is ever consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= timer_out;
            r_sync      <= r_sync_meta;
        end
    end

    assign w_cnt_done = (r_cnt == '0);
    assign w_last     = (r_idx == C_IDX_LAST);
    assign w_capture  = (r_state == S_SETTLE) && w_cnt_done && !abort;
    assign w_acc_sum  = r_acc + ACC_W'(r_sync[5:0]);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) w_next_state = S_ARM;
            end
            S_ARM: begin
                if (abort)           w_next_state = S_IDLE;
                else if (w_cnt_done) w_next_state = S_MEASURE;
            end
            S_MEASURE: begin
                if (abort)           w_next_state = S_IDLE;
                else if (w_cnt_done) w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)           w_next_state = S_IDLE;
                else if (w_cnt_done) w_next_state = w_last ? S_DONE : S_ARM;
            end
            S_DONE: begin
                if (result_ready || abort) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up with the state register without any input-to-output path.
        w_slow_clk_nxt = (w_next_state == S_MEASURE) || (w_next_state == S_SETTLE);
        w_enable_nxt   = (w_next_state == S_ARM) || (w_next_state == S_MEASURE);
        w_busy_nxt     = (w_next_state != S_IDLE);
        w_valid_nxt    = (w_next_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            timer_slow_clk <= 1'b0;
            timer_enable   <= 1'b0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            timer_slow_clk <= w_slow_clk_nxt;
            timer_enable   <= w_enable_nxt;
            busy           <= w_busy_nxt;
            result_valid   <= w_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_window <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_window <= (window == '0) ? WINDOW_W'(1) : window;
                        r_acc    <= '0;
                        r_ovf    <= 1'b0;
                        r_idx    <= '0;
                        r_cnt    <= C_ARM_LOAD;
                    end
                end
                S_ARM: begin
                    if (w_cnt_done) r_cnt <= CNT_W'(r_window) - C_CNT_ONE;
                    else            r_cnt <= r_cnt - C_CNT_ONE;
                end
                S_MEASURE: begin
                    if (w_cnt_done) r_cnt <= C_SETTLE_LOAD;
                    else            r_cnt <= r_cnt - C_CNT_ONE;
                end
                S_SETTLE: begin
                    // Settle spans the synchroniser delay, so the frozen
                    // count is fully through r_sync by the last cycle.
                    if (w_cnt_done) begin
                        r_acc <= w_acc_sum;
                        r_ovf <= r_ovf | r_sync[6];
                        r_idx <= w_last ? '0 : (r_idx + C_IDX_ONE);
                        r_cnt <= C_ARM_LOAD;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Results only change on entry to DONE; aborts leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_count    <= '0;
            result_signal   <= 1'b0;
            result_overflow <= 1'b0;
        end else if (w_capture && w_last) begin
            result_count    <= w_acc_sum;
            result_signal   <= r_sync[7];
            result_overflow <= r_ovf | r_sync[6];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ring_osc_timer_ctrl
// Brief    : Scoreboard bench for ring_osc_timer_ctrl with a behavioural timer.
// Revision : 1.0  initial release
// ============================================================================
module tb_ring_osc_timer_ctrl;

    localparam int WINDOW_W = 16;
    localparam int ARM_C    = 4;
    localparam int SET_C    = 4;
    localparam int ACC_L2   = 2;
    localparam int RES_W    = 6 + ACC_L2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [WINDOW_W-1:0] window = '0;
    logic [7:0]          timer_out = 8'h00;
    logic                result_ready = 1'b0;
    logic                timer_slow_clk;
    logic                timer_enable;
    logic                busy;
    logic                result_valid;
    logic [RES_W-1:0]    result_count;
    logic                result_signal;
    logic                result_overflow;

    ring_osc_timer_ctrl #(
        .WINDOW_W      (WINDOW_W),
        .ARM_CYCLES    (ARM_C),
        .SETTLE_CYCLES (SET_C),
        .ACCUM_LOG2    (ACC_L2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .window          (window),
        .timer_out       (timer_out),
        .timer_slow_clk  (timer_slow_clk),
        .timer_enable    (timer_enable),
        .busy            (busy),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_count    (result_count),
        .result_signal   (result_signal),
        .result_overflow (result_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint cnt;
        longint sig;
        longint ovf;
        longint start_cyc;
        longint lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] tq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    longint     cyc = 0;
    longint     s_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_sc = 1'b0;
    logic       prev_meas = 1'b0;
    int         low_len = 0;
    int         meas_len = 0;
    int         last_meas_len = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural timer: a window's reading appears when the gate rises and
    // clears when it falls.
    always @(posedge timer_slow_clk) begin
        if (tq.size() > 0) timer_out = tq.pop_front();
        else               timer_out = 8'h00;
    end
    always @(negedge timer_slow_clk) timer_out = 8'h00;

    // Result monitor: each new result is compared with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && result_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("result_count",    result_count,    e.cnt);
                check("result_signal",   result_signal,   e.sig);
                check("result_overflow", result_overflow, e.ovf);
                check("latency",         cyc - e.start_cyc, e.lat);
            end
        end
        prev_valid = rst_n && result_valid;
    end

    // Gate monitor: the counters must see at least ARM_C low cycles per window.
    always @(negedge clk) begin
        if (!timer_slow_clk) begin
            low_len++;
        end else if (!prev_sc) begin
            check("arm_low_cycles", (low_len >= ARM_C) ? 1 : 0, 1);
            low_len = 0;
        end
        if (timer_slow_clk && timer_enable) begin
            meas_len++;
        end else if (prev_meas) begin
            last_meas_len = meas_len;
            meas_len = 0;
        end
        prev_sc   = timer_slow_clk;
        prev_meas = timer_slow_clk && timer_enable;
    end

    task automatic do_start(input logic [WINDOW_W-1:0] w, input bit push,
                            input longint c, input longint sg, input longint ov,
                            input longint lat);
        exp_t e;
        window = w;
        start  = 1'b1;
        s_cyc  = cyc;
        if (push) begin
            e.cnt = c; e.sig = sg; e.ovf = ov; e.start_cyc = cyc; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, input string nm);
        int k = 0;
        while (!result_valid && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (!result_valid) check(nm, 0, 1);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("busy_after_handshake", busy, 0);
    endtask

    initial begin
        logic [RES_W-1:0] held_cnt;
        bit               stable;
        exp_t             e;

        repeat (3) @(negedge clk);
        check("rst_busy",  busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_slow",  timer_slow_clk, 0);
        check("rst_en",    timer_enable, 0);
        check("rst_count", result_count, 0);
        check("rst_sig",   result_signal, 0);
        check("rst_ovf",   result_overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A: four identical readings, window 10
        repeat (4) tq.push_back(8'hA5);
        do_start(16'd10, 1, 148, 1, 0, 73);
        check("busy_rise", busy, 1);
        wait_valid(200, "timeout_a");
        handshake();

        // B: saturated counts, strobe on third reading, stray start mid-run
        tq.push_back(8'h3F); tq.push_back(8'h3F);
        tq.push_back(8'h7F); tq.push_back(8'h3F);
        do_start(16'd5, 1, 252, 0, 1, 53);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(200, "timeout_b");
        held_cnt = result_count;
        stable   = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!result_valid || result_count !== held_cnt) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        handshake();
        repeat (30) @(negedge clk);
        check("no_restart", busy, 0);

        // C: window 0 acts as 1
        tq.push_back(8'h01); tq.push_back(8'h02);
        tq.push_back(8'h03); tq.push_back(8'h84);
        do_start(16'd0, 1, 10, 1, 0, 37);
        wait_valid(200, "timeout_c");
        check("window0_meas_len", last_meas_len, 1);
        handshake();

        // Abort inside the second measurement window
        tq.push_back(8'hA5); tq.push_back(8'hA5);
        do_start(16'd10, 0, 0, 0, 0, 0);
        while ((cyc - s_cyc) < 26) @(negedge clk);
        check("in_second_measure", timer_slow_clk && timer_enable, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tq.delete();
        check("abort_busy",  busy, 0);
        check("abort_en",    timer_enable, 0);
        check("abort_slow",  timer_slow_clk, 0);
        check("abort_valid", result_valid, 0);
        check("abort_keep_count", result_count, 10);
        check("abort_keep_sig",   result_signal, 1);
        check("abort_keep_ovf",   result_overflow, 0);

        // start together with abort in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 0);

        // D: back-to-back with start held through the handshake
        repeat (8) tq.push_back(8'h10);
        window = 16'd2;
        start  = 1'b1;
        e.cnt = 64; e.sig = 0; e.ovf = 0; e.start_cyc = cyc; e.lat = 41;
        sb.push_back(e);
        wait_valid(200, "timeout_d1");
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("b2b_busy_low", busy, 0);
        e.start_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_high", busy, 1);
        wait_valid(200, "timeout_d2");
        handshake();

        // Asynchronous reset in the middle of a window
        repeat (4) tq.push_back(8'h21);
        do_start(16'd10, 0, 0, 0, 0, 0);
        begin
            int k = 0;
            while (!(timer_slow_clk && timer_enable) && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check("reset_in_measure", timer_slow_clk && timer_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  busy, 0);
        check("arst_en",    timer_enable, 0);
        check("arst_slow",  timer_slow_clk, 0);
        check("arst_valid", result_valid, 0);
        check("arst_count", result_count, 0);
        tq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // E: normal run after reset, window 1
        repeat (4) tq.push_back(8'h05);
        do_start(16'd1, 1, 20, 0, 0, 37);
        wait_valid(200, "timeout_e");
        handshake();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
